// File: rtl/fft_pkg.sv
// Shared constants, state type and index helper for the FFT output
// reorder buffer.
package fft_pkg;

  localparam int FFT_DW    = 16;
  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;

  typedef enum logic {
    IDLE,
    READ
  } rd_state_t;

  // Reverse the low w bits of a; bits above w are zero.
  function automatic logic [31:0] bitrev(
    input logic [31:0] a,
    input int          w
  );
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < w) r[b] = a[w-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_rb_bank.sv
// One reorder bank: N x W register file, synchronous write port and a
// registered read port that returns zero when not enabled.
module fft_rb_bank #(
  parameter int W  = 32,
  parameter int N  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [N];
  logic [W-1:0] rdata_q;
  logic [W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = '0;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT bins in, natural order out,
// frame n read while frame n+1 is written.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int DW    = FFT_DW,
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [DW-1:0]    in_r,
  input  logic [DW-1:0]    in_i,
  output logic             out_valid,
  output logic             out_sof,
  output logic [LOG2N-1:0] out_idx,
  output logic [DW-1:0]    out_r,
  output logic [DW-1:0]    out_i,
  output logic             sync_err
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  rd_state_t        state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sof_q, out_sof_d;
  logic [LOG2N-1:0] out_idx_q, out_idx_d;
  logic             sync_err_q, sync_err_d;

  logic             resync;
  logic [LOG2N-1:0] w_eff;
  logic [LOG2N-1:0] waddr;
  logic             rd_start;
  logic             we0, we1, re0, re1;
  logic [2*DW-1:0]  rdata0, rdata1, rdata;

  // A mid-frame sof restarts the frame in the same bank at w=0.
  always_comb begin
    resync     = in_valid && in_sof && (wr_cnt_q != '0);
    w_eff      = resync ? '0 : wr_cnt_q;
    waddr      = LOG2N'(bitrev(32'(w_eff), LOG2N));
    rd_start   = in_valid && (w_eff == LAST);
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    sync_err_d = resync;
    if (in_valid) begin
      wr_cnt_d = rd_start ? '0 : w_eff + 1'b1;
    end
    if (rd_start) wr_bank_d = ~wr_bank_q;
    we0 = in_valid && !wr_bank_q;
    we1 = in_valid && wr_bank_q;
  end

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          state_d   = READ;
          rd_cnt_d  = '0;
          rd_bank_d = wr_bank_q;
        end
      end
      READ: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_start) begin
          rd_cnt_d  = '0;
          rd_bank_d = wr_bank_q;
        end else if (rd_cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    re0         = (state_q == READ) && !rd_bank_q;
    re1         = (state_q == READ) && rd_bank_q;
    out_valid_d = (state_q == READ);
    out_sof_d   = (state_q == READ) && (rd_cnt_q == '0);
    out_idx_d   = (state_q == READ) ? rd_cnt_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_idx_q   <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_idx_q   <= out_idx_d;
      sync_err_q  <= sync_err_d;
    end
  end

  fft_rb_bank #(
    .W  (2*DW),
    .N  (N),
    .AW (LOG2N)
  ) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we0),
    .waddr (waddr),
    .wdata ({in_r, in_i}),
    .re    (re0),
    .raddr (rd_cnt_q),
    .rdata (rdata0)
  );

  fft_rb_bank #(
    .W  (2*DW),
    .N  (N),
    .AW (LOG2N)
  ) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we1),
    .waddr (waddr),
    .wdata ({in_r, in_i}),
    .re    (re1),
    .raddr (rd_cnt_q),
    .rdata (rdata1)
  );

  // Idle bank read registers return zero, so OR acts as the output mux.
  assign rdata     = rdata0 | rdata1;
  assign out_r     = rdata[2*DW-1:DW];
  assign out_i     = rdata[DW-1:0];
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_idx   = out_idx_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder against a frame-level
// reference model of the reorder buffer.
module tb_fft_out_reorder;

  localparam int DW = 16;
  localparam int N  = 32;
  localparam int L  = 5;
  localparam int NC = 20000;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_i;
  logic          out_valid;
  logic          out_sof;
  logic [L-1:0]  out_idx;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;
  logic          sync_err;

  fft_out_reorder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_idx   (out_idx),
    .out_r     (out_r),
    .out_i     (out_i),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;
  int cn;

  // Expected outputs, indexed by the clock edge that produces them.
  bit          ev  [NC];
  bit          es  [NC];
  bit          ee  [NC];
  bit [L-1:0]  ei  [NC];
  bit [DW-1:0] er  [NC];
  bit [DW-1:0] eim [NC];

  int          w;
  bit [DW-1:0] br [N];
  bit [DW-1:0] bi [N];

  function automatic int rev(input int x);
    int r;
    int v;
    r = 0;
    v = x;
    for (int k = 0; k < L; k++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic [39:0] obs();
    return {out_valid, out_sof, sync_err,
            out_valid ? out_idx : 5'd0,
            out_valid ? out_r : 16'd0,
            out_valid ? out_i : 16'd0};
  endfunction

  function automatic logic [39:0] expv();
    return {ev[cn], es[cn], ee[cn],
            ev[cn] ? ei[cn] : 5'd0,
            ev[cn] ? er[cn] : 16'd0,
            ev[cn] ? eim[cn] : 16'd0};
  endfunction

  task automatic mreset();
    for (int c = 0; c < NC; c++) begin
      ev[c] = 0; es[c] = 0; ee[c] = 0;
      ei[c] = '0; er[c] = '0; eim[c] = '0;
    end
    w = 0;
  endtask

  // Drive one cycle (at negedge), advance the model at posedge, return
  // at the following negedge.
  task automatic cyc(input bit v, input bit s,
                     input logic [DW-1:0] r, input logic [DW-1:0] i);
    in_valid = v; in_sof = s; in_r = r; in_i = i;
    @(posedge clk);
    cn++;
    if (v) begin
      if (s && w != 0) begin
        ee[cn] = 1;
        w = 0;
      end
      br[w] = r;
      bi[w] = i;
      w++;
      if (w == N) begin
        for (int j = 0; j < N; j++) begin
          if (cn + 1 + j < NC) begin
            ev[cn+1+j]  = 1;
            es[cn+1+j]  = (j == 0);
            ei[cn+1+j]  = L'(j);
            er[cn+1+j]  = br[rev(j)];
            eim[cn+1+j] = bi[rev(j)];
          end
        end
        w = 0;
      end
    end
    @(negedge clk);
    in_valid = 0; in_sof = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; in_sof = 0; in_r = '0; in_i = '0;
    mreset();
    repeat (2) @(negedge clk);
    n_run++;
    if ({out_valid, out_sof, sync_err, out_idx, out_r, out_i} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset got=%h exp=0",
               {out_valid, out_sof, sync_err, out_idx, out_r, out_i});
    end
    rst_n = 1;
  endtask

  task automatic test_single();
    for (int k = 0; k < N; k++) begin
      cyc(1, k == 0, 16'(rev(k)), 16'(-rev(k)));
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL single cyc=%0d got=%h exp=%h", cn, obs(), expv());
      end
    end
    for (int k = 0; k < N + 3; k++) begin
      cyc(0, 0, '0, '0);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL single_out cyc=%0d got=%h exp=%h", cn, obs(), expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        cyc(1, k == 0, 16'(rev(k) + (f == 2 ? 100 : 0)), 16'($urandom));
        n_run++;
        if (obs() !== expv()) begin
          n_fail++;
          $display("FAIL b2b cyc=%0d got=%h exp=%h", cn, obs(), expv());
        end
      end
    end
    for (int k = 0; k < N + 3; k++) begin
      cyc(0, 0, '0, '0);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL b2b_out cyc=%0d got=%h exp=%h", cn, obs(), expv());
      end
    end
  endtask

  task automatic test_gaps();
    for (int k = 0; k < 2 * N + N + 3; k++) begin
      if (k < 2 * N && k % 2 == 0)
        cyc(1, k == 0, 16'($urandom), 16'($urandom));
      else
        cyc(0, 0, '0, '0);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL gaps cyc=%0d got=%h exp=%h", cn, obs(), expv());
      end
    end
  endtask

  task automatic test_resync();
    for (int k = 0; k < 10 + N + N + 3; k++) begin
      if (k < 10 + N)
        cyc(1, k == 0 || k == 10, 16'($urandom), 16'($urandom));
      else
        cyc(0, 0, '0, '0);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL resync cyc=%0d got=%h exp=%h", cn, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < N + 16; k++) begin
      if (k < N) cyc(1, k == 0, 16'($urandom) | 16'h1, 16'($urandom));
      else       cyc(0, 0, '0, '0);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", cn, obs(), expv());
      end
    end
    #2 rst_n = 0;
    #1;
    n_run++;
    if ({out_valid, out_sof, out_r, out_i} !== 34'd0) begin
      n_fail++;
      $display("FAIL rstmid_async got=%h exp=0",
               {out_valid, out_sof, out_r, out_i});
    end
    mreset();
    @(posedge clk);
    cn++;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < N + N + 3; k++) begin
      if (k < N) cyc(1, k == 0, 16'($urandom), 16'($urandom));
      else       cyc(0, 0, '0, '0);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", cn, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 200; f++) begin
      for (int k = 0; k < N; k++) begin
        int g;
        g = ($urandom % 3 == 0) ? $urandom_range(1, 3) : 0;
        for (int q = 0; q < g; q++) begin
          cyc(0, 0, '0, '0);
          n_run++;
          if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL random_gap cyc=%0d got=%h exp=%h", cn, obs(), expv());
          end
        end
        cyc(1, (k == 0) && ($urandom % 2 == 0), 16'($urandom), 16'($urandom));
        n_run++;
        if (obs() !== expv()) begin
          n_fail++;
          $display("FAIL random cyc=%0d got=%h exp=%h", cn, obs(), expv());
        end
      end
    end
    for (int k = 0; k < N + 3; k++) begin
      cyc(0, 0, '0, '0);
      n_run++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random_out cyc=%0d got=%h exp=%h", cn, obs(), expv());
      end
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    cn = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_resync();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
